pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
//  Each cycle it arbitrates between data-memory wait, EX-stage redirect, load-use hazard and
//  instruction-fetch miss, and drives the PC write enable and every inter-stage register's hold/bubble control.
//  It also counts stall and flush cycles and flags data-memory timeout.
// PARAMETERS
//  CNT_W         32   width of perf_stall_cnt / perf_flush_cnt (saturating)
//  DMEM_TIMEOUT  255  max consecutive cycles dmem_req & !dmem_ready before bus_err; >=1
//  TO_W          8    width of wait counter; must hold DMEM_TIMEOUT
// PORTS
//  clk             in   1      clock, all state on posedge
//  rst             in   1      synchronous, active-high reset
//  imem_valid      in   1      fetch response for outstanding request valid this cycle
//  ex_redirect     in   1      EX resolved taken branch/jump; target on PC mux
//  id_ex_mem_read  in   1      instruction in ID/EX is a load
//  id_ex_rd        in   5      dest reg of instruction in ID/EX
//  id_rs1, id_rs2  in   5      source regs of instruction in ID
//  id_use_rs1/rs2  in   1      ID instruction reads rs1 / rs2
//  dmem_req        in   1      MEM stage accessing data memory
//  dmem_ready      in   1      data memory completes access this cycle
//  pc_we           out  1      PC register load enable
//  if_id_hazard    out  1      IF/ID hold (wins over flush inside IF/ID)
//  if_id_flush     out  1      IF/ID loads NOP 32'h0000_0013
//  id_ex_en        out  1      ID/EX load enable (0 = hold)
//  id_ex_flush     out  1      ID/EX loads bubble
//  ex_mem_en       out  1      EX/MEM load enable
//  mem_wb_flush    out  1      MEM/WB loads bubble
//  perf_stall_cnt  out  CNT_W  cycles with pc_we=0 outside reset
//  perf_flush_cnt  out  CNT_W  cycles with if_id_flush=1 due to redirect
//  bus_err         out  1      sticky; set on dmem timeout, cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, state RUN, wait counter 0. Outputs are combinational from
//   inputs+state; state/counters update on posedge clk.
//  Priority, highest first (a lower rule is evaluated only if no higher one fires):
//  1 FREEZE  dmem_req & !dmem_ready: pc_we=0, if_id_hazard=1, id_ex_en=0, ex_mem_en=0,
//            mem_wb_flush=1; redirect/load-use deferred (EX/ID held, inputs stay stable).
//  2 REDIR   ex_redirect: pc_we=1, if_id_flush=1, id_ex_flush=1, if_id_hazard=0;
//            if imem_valid=0 (fetch in flight) next state IKILL. Redirect beats load-use.
//  3 LDUSE   id_ex_mem_read & id_ex_rd!=0 & ((id_use_rs1&rd==rs1)|(id_use_rs2&rd==rs2)):
//            pc_we=0, if_id_hazard=1, id_ex_flush=1; exactly one bubble.
//  4 FMISS   !imem_valid or state IKILL: pc_we=0, if_id_flush=1 (bubble into ID).
//  5 RUN     pc_we=1, all enables 1, no flush/hold.
//  id_ex_en=ex_mem_en=1 whenever rule 1 is inactive.
//  FSM: RUN -> IKILL on rule 2 with imem_valid=0. IKILL -> RUN when imem_valid=1 (response
//   dropped via if_id_flush, pc_we=0 for that cycle); further redirects in IKILL stay IKILL.
//   Freeze in IKILL keeps IKILL.
//  Wait counter: +1 each cycle rule 1 fires, cleared otherwise; reaching DMEM_TIMEOUT sets bus_err
//   (pipeline stays frozen; no recovery besides rst).
//  Counters saturate at all-ones; never wrap. rst mid-freeze/IKILL returns to RUN next cycle.
// STRUCTURE
//  pipeline_ctrl_pkg: state enum {RUN, IKILL}, NOP_INSTR=32'h0000_0013, RESET_PC=32'h8000_0000.
//  Sub-module load_use_detect (pure combinational compare, rule 3); counters inline.
// TESTING
//  1 lw x5 in EX, ID add x6,x5,x1 -> one cycle pc_we=0, if_id_hazard=1, id_ex_flush=1; next cycle RUN.
//  2 ex_redirect with imem_valid=1 -> pc_we=1, if_id_flush=id_ex_flush=1, if_id_hazard=0; perf_flush_cnt +1.
//  3 ex_redirect with imem_valid=0, then imem_valid=1 after 3 cycles -> IKILL 3 cycles, returned
//    word dropped (if_id_flush=1, pc_we=0), then RUN.
//  4 dmem_req=1, dmem_ready low 4 cycles while ex_redirect=1 -> 4 freeze cycles, redirect fires cycle 5.
//  5 load-use with id_ex_rd=0 -> no stall; redirect+load-use same cycle -> redirect outputs only.
//  6 DMEM_TIMEOUT=4, dmem_ready never -> bus_err=1 after 4th wait cycle; rst clears all to 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush scheduler
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_IKILL = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and pipeline control outputs of the scheduler
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             imem_valid;
    logic             ex_redirect;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_we;
    logic             if_id_hazard;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_flush;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;
    logic             bus_err;

    modport master (
        output imem_valid, ex_redirect, id_ex_mem_read, id_ex_rd, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, dmem_req, dmem_ready,
        input  pc_we, if_id_hazard, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_flush, perf_stall_cnt, perf_flush_cnt, bus_err
    );

    modport slave (
        input  imem_valid, ex_redirect, id_ex_mem_read, id_ex_rd, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, dmem_req, dmem_ready,
        output pc_we, if_id_hazard, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_flush, perf_stall_cnt, perf_flush_cnt, bus_err
    );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// rtl/pipeline_ctrl_load_use_detect.sv - load-use hazard compare between ID/EX load and ID sources
module load_use_detect (
    input  logic       mem_read,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       hazard
);
    // x0 is never a real dependency, so a load targeting it cannot stall ID
    assign hazard = mem_read && (rd != 5'd0) &&
                    ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush scheduler for the 5-stage pipeline with perf counters and dmem timeout
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DMEM_TIMEOUT = 255,
    parameter int TO_W         = 8
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave bus
);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(DMEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(DMEM_TIMEOUT - 1);

    state_t           state;
    logic [TO_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             bus_err_q;

    logic freeze;
    logic ld_use;
    logic redir_fire;
    logic pc_we_c, if_id_hazard_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c, ex_mem_en_c, mem_wb_flush_c;

    load_use_detect u_load_use_detect (
        .mem_read (bus.id_ex_mem_read),
        .rd       (bus.id_ex_rd),
        .rs1      (bus.id_rs1),
        .rs2      (bus.id_rs2),
        .use_rs1  (bus.id_use_rs1),
        .use_rs2  (bus.id_use_rs2),
        .hazard   (ld_use)
    );

    assign freeze     = bus.dmem_req && !bus.dmem_ready;
    assign redir_fire = !rst && !freeze && bus.ex_redirect;

    always_comb begin
        pc_we_c        = 1'b0;
        if_id_hazard_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_en_c     = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_en_c    = 1'b0;
        mem_wb_flush_c = 1'b0;
        if (!rst) begin
            id_ex_en_c  = 1'b1;
            ex_mem_en_c = 1'b1;
            if (freeze) begin
                if_id_hazard_c = 1'b1;
                id_ex_en_c     = 1'b0;
                ex_mem_en_c    = 1'b0;
                mem_wb_flush_c = 1'b1;
            end else if (bus.ex_redirect) begin
                pc_we_c       = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end else if (ld_use) begin
                if_id_hazard_c = 1'b1;
                id_ex_flush_c  = 1'b1;
            end else if (!bus.imem_valid || state == ST_IKILL) begin
                if_id_flush_c = 1'b1;
            end else begin
                pc_we_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (freeze) begin
                if (wait_cnt != TO_LIMIT) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= TO_LAST) bus_err_q <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            // A redirect with a fetch still in flight must discard that stale response
            if (!freeze) begin
                if (bus.ex_redirect) begin
                    if (!bus.imem_valid) state <= ST_IKILL;
                end else if (bus.imem_valid) begin
                    state <= ST_RUN;
                end
            end

            if (!pc_we_c && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (redir_fire && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.pc_we          = pc_we_c;
    assign bus.if_id_hazard   = if_id_hazard_c;
    assign bus.if_id_flush    = if_id_flush_c;
    assign bus.id_ex_en       = id_ex_en_c;
    assign bus.id_ex_flush    = id_ex_flush_c;
    assign bus.ex_mem_en      = ex_mem_en_c;
    assign bus.mem_wb_flush   = mem_wb_flush_c;
    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
    assign bus.bus_err        = bus_err_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized checks of pipeline_ctrl against a rule-table reference model
module tb_pipeline_ctrl;
    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference state: whether a stale fetch is pending, wait streak, counters, error flag
    bit m_ikill = 0;
    int m_waits = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_err   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit iv, input bit red, input bit mr,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input bit dq, input bit dr);
        int rule;
        bit lu;
        bit e_pc;
        @(negedge clk);
        rst                = r;
        bus.imem_valid     = iv;
        bus.ex_redirect    = red;
        bus.id_ex_mem_read = mr;
        bus.id_ex_rd       = rd;
        bus.id_rs1         = rs1;
        bus.id_rs2         = rs2;
        bus.id_use_rs1     = u1;
        bus.id_use_rs2     = u2;
        bus.dmem_req       = dq;
        bus.dmem_ready     = dr;
        #1;
        lu = mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
        if (r)                 rule = 0;
        else if (dq && !dr)    rule = 1;
        else if (red)          rule = 2;
        else if (lu)           rule = 3;
        else if (!iv || m_ikill) rule = 4;
        else                   rule = 5;
        e_pc = (rule == 2 || rule == 5);
        chk("pc_we",        32'(bus.pc_we),        32'(e_pc));
        chk("if_id_hazard", 32'(bus.if_id_hazard), 32'(rule == 1 || rule == 3));
        chk("if_id_flush",  32'(bus.if_id_flush),  32'(rule == 2 || rule == 4));
        chk("id_ex_en",     32'(bus.id_ex_en),     32'(rule >= 2));
        chk("id_ex_flush",  32'(bus.id_ex_flush),  32'(rule == 2 || rule == 3));
        chk("ex_mem_en",    32'(bus.ex_mem_en),    32'(rule >= 2));
        chk("mem_wb_flush", 32'(bus.mem_wb_flush), 32'(rule == 1));
        chk("perf_stall",   32'(bus.perf_stall_cnt), 32'(m_stall));
        chk("perf_flush",   32'(bus.perf_flush_cnt), 32'(m_flush));
        chk("bus_err",      32'(bus.bus_err),      32'(m_err));
        @(posedge clk);
        if (rule == 0) begin
            m_ikill = 0; m_waits = 0; m_stall = 0; m_flush = 0; m_err = 0;
        end else begin
            if (rule == 1) begin
                m_waits++;
                if (m_waits >= TIMEOUT) m_err = 1;
            end else begin
                m_waits = 0;
            end
            if (rule == 2 && !iv) m_ikill = 1;
            else if (rule >= 3 && iv) m_ikill = 0;
            if (!e_pc && m_stall < CNT_MAX) m_stall++;
            if (rule == 2 && m_flush < CNT_MAX) m_flush++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.imem_valid = 1'b1; bus.ex_redirect = 1'b0; bus.id_ex_mem_read = 1'b0;
        bus.id_ex_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
        @(posedge clk);
        do_reset();
        idle(2);

        // lw x5 in EX, add x6,x5,x1 in ID: single bubble then run
        step(0, 1, 0, 1, 5, 5, 1, 1, 1, 0, 0);
        idle(1);

        // redirect with fetch response present
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // redirect with fetch in flight; response arrives 3 cycles later and is dropped
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // freeze for 4 cycles with a pending redirect; redirect fires on cycle 5
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        do_reset();

        // load into x0 never stalls; redirect beats load-use
        step(0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 5, 5, 0, 1, 0, 0, 0);
        idle(1);

        // dmem never ready: bus_err after the 4th wait cycle, sticky until reset
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        do_reset();
        idle(1);

        // long fetch miss drives the stall counter into saturation
        for (int i = 0; i < CNT_MAX + 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        do_reset();

        for (int i = 0; i < 500; i++) begin
            step(($urandom % 200) == 0,
                 ($urandom % 4) != 0,
                 ($urandom % 5) == 0,
                 ($urandom % 2) == 0,
                 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
                 ($urandom % 2) == 0, ($urandom % 2) == 0,
                 ($urandom % 4) == 0, ($urandom % 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
